// File: rtl/in_stage_pkg.sv
// Shared definitions for the packet-buffer input stage and its output-stage peer.
package in_stage_pkg;

  localparam int         PKT_LEN   = 188;   // bytes per packet, addresses 0..PKT_LEN-1
  localparam logic [7:0] SYNC_BYTE = 8'h47; // required first byte of every packet
  localparam int         LOCK_PKTS = 3;     // good boundaries needed for lock (1..7)
  localparam int         AW        = 8;     // RAM address width

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2
  } state_e;

endpackage

// File: rtl/in_stage_if.sv
// Byte-stream input and ping-pong RAM write port of the input stage.
interface in_stage_if;
  import in_stage_pkg::*;

  logic          CEI;
  logic          Valid_in;
  logic [7:0]    In_byte;
  logic          WE;
  logic [AW-1:0] WrAdd;
  logic [7:0]    Wr_byte;
  logic          BANK;
  logic          DONE;
  logic          locked;
  logic          sync_err;

  // Byte source side: drives the stream, observes the RAM port and status.
  modport master (
    output CEI, Valid_in, In_byte,
    input  WE, WrAdd, Wr_byte, BANK, DONE, locked, sync_err
  );

  // Input stage side.
  modport slave (
    input  CEI, Valid_in, In_byte,
    output WE, WrAdd, Wr_byte, BANK, DONE, locked, sync_err
  );

endinterface

// File: rtl/in_sync_tracker.sv
// Framing lock tracker: counts consecutive good packet boundaries and flags misses.
module in_sync_tracker
  import in_stage_pkg::*;
(
  input  logic clk,
  input  logic reset,          // asynchronous, active-low
  input  logic boundary_ok,    // sync byte seen where one was expected
  input  logic boundary_miss,  // something else seen where a sync byte was expected
  output logic locked,
  output logic sync_err
);

  localparam logic [2:0] LOCK_CNT = 3'(LOCK_PKTS);

  logic [2:0] cnt_q, cnt_d;
  logic       locked_q, locked_d;
  logic       sync_err_q, sync_err_d;

  // Next lock count / lock flag; a miss wipes the history, a hit counts up to saturation.
  always_comb begin
    cnt_d      = cnt_q;
    locked_d   = locked_q;
    sync_err_d = boundary_miss;
    if (boundary_miss) begin
      cnt_d    = 3'd0;
      locked_d = 1'b0;
    end else if (boundary_ok) begin
      if (cnt_q < LOCK_CNT) cnt_d = cnt_q + 3'd1;
      if (cnt_d == LOCK_CNT) locked_d = 1'b1;
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= 3'd0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign locked   = locked_q;
  assign sync_err = sync_err_q;

endmodule

// File: rtl/in_stage.sv
// Input stage: hunts for sync, frames PKT_LEN-byte packets into a ping-pong RAM.
module in_stage
  import in_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,   // asynchronous, active-low
  in_stage_if.slave  bus
);

  // Address of the second-to-last byte: the next accept in FILL closes the packet.
  localparam logic [AW-1:0] PRE_LAST = AW'(PKT_LEN - 2);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] wr_add_q, wr_add_d;
  logic [7:0]    wr_byte_q, wr_byte_d;
  logic          bank_q, bank_d;
  logic          done_q, done_d;
  logic          pend_q, pend_d;   // packet just closed; DONE and bank flip next clk
  logic          accept;
  logic          is_sync;
  logic          boundary_ok;
  logic          boundary_miss;
  logic          locked;
  logic          sync_err;

  assign accept  = bus.CEI && bus.Valid_in;
  assign is_sync = (bus.In_byte == SYNC_BYTE);

  // Framing FSM, address counter and write-port next values.
  always_comb begin
    state_d       = state_q;
    we_d          = 1'b0;
    wr_add_d      = wr_add_q;
    wr_byte_d     = wr_byte_q;
    pend_d        = 1'b0;
    done_d        = pend_q;
    bank_d        = bank_q ^ pend_q;
    boundary_ok   = 1'b0;
    boundary_miss = 1'b0;
    case (state_q)
      HUNT: begin
        if (accept && is_sync) begin
          we_d      = 1'b1;
          wr_add_d  = '0;
          wr_byte_d = bus.In_byte;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          we_d      = 1'b1;
          wr_add_d  = wr_add_q + AW'(1);
          wr_byte_d = bus.In_byte;
          if (wr_add_q == PRE_LAST) begin
            state_d = CHECK;
            pend_d  = 1'b1;
          end
        end
      end
      CHECK: begin
        if (accept) begin
          if (is_sync) begin
            we_d        = 1'b1;
            wr_add_d    = '0;
            wr_byte_d   = bus.In_byte;
            state_d     = FILL;
            boundary_ok = 1'b1;
          end else begin
            boundary_miss = 1'b1;
            state_d       = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      we_q      <= 1'b0;
      wr_add_q  <= '0;
      wr_byte_q <= 8'd0;
      bank_q    <= 1'b0;
      done_q    <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      wr_add_q  <= wr_add_d;
      wr_byte_q <= wr_byte_d;
      bank_q    <= bank_d;
      done_q    <= done_d;
      pend_q    <= pend_d;
    end
  end

  in_sync_tracker u_tracker (
    .clk           (clk),
    .reset         (reset),
    .boundary_ok   (boundary_ok),
    .boundary_miss (boundary_miss),
    .locked        (locked),
    .sync_err      (sync_err)
  );

  assign bus.WE       = we_q;
  assign bus.WrAdd    = wr_add_q;
  assign bus.Wr_byte  = wr_byte_q;
  assign bus.BANK     = bank_q;
  assign bus.DONE     = done_q;
  assign bus.locked   = locked;
  assign bus.sync_err = sync_err;

endmodule

// File: tb/tb_in_stage.sv
// Bench for in_stage: directed scenarios with randomized gaps/payloads, checked every
// cycle against a packet-level reference model.
module tb_in_stage;

  logic clk = 1'b0;
  logic reset;

  in_stage_if bus();

  in_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_we     = 0;
  int n_done   = 0;
  int n_err    = 0;
  int n_coinc  = 0;

  // Reference model: bytes accepted into the current packet (-1 = searching for sync,
  // 188 = packet full, next accepted byte must be a sync byte).
  int         m_pos;
  int         m_good;
  bit         m_done_due;
  bit         exp_we, exp_bank, exp_done, exp_locked, exp_err;
  int         exp_add;
  logic [7:0] exp_byte;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos      = -1;
    m_good     = 0;
    m_done_due = 1'b0;
    exp_we     = 1'b0;
    exp_bank   = 1'b0;
    exp_done   = 1'b0;
    exp_locked = 1'b0;
    exp_err    = 1'b0;
    exp_add    = 0;
    exp_byte   = 8'd0;
  endtask

  // Predict outputs visible after the coming clock edge.
  task automatic model_step(input bit acc, input logic [7:0] b);
    exp_we   = 1'b0;
    exp_err  = 1'b0;
    exp_done = 1'b0;
    if (m_done_due) begin
      exp_done   = 1'b1;
      exp_bank   = ~exp_bank;
      m_done_due = 1'b0;
    end
    if (acc) begin
      if (m_pos < 0 || m_pos == 188) begin
        if (b == 8'h47) begin
          if (m_pos == 188) begin
            m_good = (m_good < 3) ? m_good + 1 : 3;
            if (m_good == 3) exp_locked = 1'b1;
          end
          exp_we = 1'b1; exp_add = 0; exp_byte = b;
          m_pos  = 1;
        end else if (m_pos == 188) begin
          exp_err    = 1'b1;
          m_good     = 0;
          exp_locked = 1'b0;
          m_pos      = -1;
        end
      end else begin
        exp_we = 1'b1; exp_add = m_pos; exp_byte = b;
        m_pos++;
        if (m_pos == 188) m_done_due = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("WE",       bus.WE,       exp_we);
    check_val("WrAdd",    bus.WrAdd,    exp_add);
    check_val("Wr_byte",  bus.Wr_byte,  exp_byte);
    check_val("BANK",     bus.BANK,     exp_bank);
    check_val("DONE",     bus.DONE,     exp_done);
    check_val("locked",   bus.locked,   exp_locked);
    check_val("sync_err", bus.sync_err, exp_err);
    if (bus.WE === 1'b1) n_we++;
    if (bus.DONE === 1'b1) n_done++;
    if (bus.sync_err === 1'b1) n_err++;
    if (bus.DONE === 1'b1 && bus.WE === 1'b1 && bus.WrAdd === '0) n_coinc++;
  endtask

  // One clock: drive inputs at the falling edge, predict, then check at the next falling edge.
  task automatic tick(input bit cei, input bit vld, input logic [7:0] b);
    bus.CEI      = cei;
    bus.Valid_in = vld;
    bus.In_byte  = b;
    model_step(cei && vld, b);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic strobe(input logic [7:0] b, input bit vld, input int gmin, input int gmax);
    int gap;
    gap = $urandom_range(gmax, gmin);
    tick(1'b1, vld, b);
    for (int i = 1; i < gap; i++) tick(1'b0, 1'b0, 8'($urandom));
  endtask

  // Send one packet of 188 accepted bytes; inv_pct = chance of a gap strobe before a byte.
  task automatic send_pkt(input logic [7:0] first, input bit ramp, input int gmin,
                          input int gmax, input int inv_pct);
    logic [7:0] b;
    for (int i = 0; i < 188; i++) begin
      while ($urandom_range(99, 0) < inv_pct) strobe(8'($urandom), 1'b0, gmin, gmax);
      b = (i == 0) ? first : (ramp ? 8'(i) : 8'($urandom));
      strobe(b, 1'b1, gmin, gmax);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'd0);
  endtask

  // Asynchronous reset pulse between clock edges, released at a falling edge.
  task automatic do_reset();
    bus.CEI      = 1'b0;
    bus.Valid_in = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_val("rst_WE",       bus.WE,       0);
    check_val("rst_WrAdd",    bus.WrAdd,    0);
    check_val("rst_Wr_byte",  bus.Wr_byte,  0);
    check_val("rst_BANK",     bus.BANK,     0);
    check_val("rst_DONE",     bus.DONE,     0);
    check_val("rst_locked",   bus.locked,   0);
    check_val("rst_sync_err", bus.sync_err, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(2);
  endtask

  int we0, done0, err0;

  initial begin
    reset        = 1'b1;
    bus.CEI      = 1'b0;
    bus.Valid_in = 1'b0;
    bus.In_byte  = 8'd0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: two ramp packets, strobe every 8 clks
    we0 = n_we; done0 = n_done;
    send_pkt(8'h47, 1'b1, 8, 8, 0);
    send_pkt(8'h47, 1'b1, 8, 8, 0);
    idle(4);
    check_val("t1_we_count",   n_we - we0,     376);
    check_val("t1_done_count", n_done - done0, 2);

    // 2: junk before sync, then one packet
    do_reset();
    we0 = n_we; err0 = n_err;
    for (int i = 0; i < 3; i++) strobe(8'h00, 1'b1, 1, 8);
    send_pkt(8'h47, 1'b0, 1, 8, 0);
    idle(4);
    check_val("t2_we_count", n_we - we0,   188);
    check_val("t2_sync_err", n_err - err0, 0);

    // 3: four good packets, then a bad boundary byte
    do_reset();
    we0 = n_we; err0 = n_err;
    for (int p = 0; p < 4; p++) send_pkt(8'h47, 1'b0, 1, 3, 0);
    idle(3);
    check_val("t3_locked", bus.locked, 1);
    strobe(8'h46, 1'b1, 4, 4);
    check_val("t3_err_count", n_err - err0, 1);
    check_val("t3_unlocked",  bus.locked,   0);
    check_val("t3_no_we_46",  n_we - we0,   4 * 188);
    for (int i = 0; i < 20; i++) strobe(8'h00, 1'b1, 1, 3);
    check_val("t3_hunt_no_we", n_we - we0, 4 * 188);

    // 4: ten invalid strobes mid-packet
    do_reset();
    we0 = n_we; done0 = n_done;
    strobe(8'h47, 1'b1, 1, 6);
    for (int i = 1; i < 60; i++) strobe(8'($urandom), 1'b1, 1, 6);
    for (int i = 0; i < 10; i++) strobe(8'($urandom), 1'b0, 1, 6);
    for (int i = 60; i < 188; i++) strobe(8'($urandom), 1'b1, 1, 6);
    idle(4);
    check_val("t4_we_count",   n_we - we0,     188);
    check_val("t4_done_count", n_done - done0, 1);

    // 5: reset at byte 100, then a fresh packet
    do_reset();
    send_pkt(8'h47, 1'b0, 1, 4, 0);
    idle(3);
    done0 = n_done;
    strobe(8'h47, 1'b1, 1, 4);
    for (int i = 1; i < 100; i++) strobe(8'($urandom), 1'b1, 1, 4);
    do_reset();
    we0 = n_we;
    send_pkt(8'h47, 1'b0, 1, 4, 0);
    idle(4);
    check_val("t5_done_count", n_done - done0, 1);
    check_val("t5_we_count",   n_we - we0,     188);

    // 6: strobe every clock, DONE lands with the next sync byte
    do_reset();
    n_coinc = 0;
    send_pkt(8'h47, 1'b0, 1, 1, 0);
    send_pkt(8'h47, 1'b0, 1, 1, 0);
    strobe(8'h47, 1'b1, 1, 1);
    idle(4);
    check_val("t6_coincident", n_coinc, 2);

    // 7: random mix of good/bad boundaries, gaps and invalid strobes
    do_reset();
    for (int p = 0; p < 8; p++) begin
      send_pkt(($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'h47, 1'b0, 1, 4, 5);
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
